melody_output_scheduler: RTL and testbench

//  Sequences melody playback from a latched 32-bit note pattern onto the shared piezo/LED outputs.

---
 rtl/melody_output_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_melody_output_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_output_scheduler.sv
// Melody playback sequencer and keypad-echo arbiter for the shared piezo/LED outputs.
// Optional REVERSE_PLAY_EN adds a play_rev input for descending playback.
module melody_output_scheduler #(
    parameter int unsigned TICK_DIV       = 5_000_000,
    parameter int unsigned NOTE_ON_TICKS  = 2,
    parameter int unsigned NOTE_GAP_TICKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pattern,
    input  logic [3:0]  play_len,
    input  logic        play_req,
`ifdef REVERSE_PLAY_EN
    input  logic        play_rev,
`endif
    output logic        play_busy,
    output logic        play_done,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        key_release,
    output logic        key_accept,
    output logic [3:0]  tone_out,
    output logic [3:0]  led_out
);

    localparam int unsigned MAX_TICKS = (NOTE_ON_TICKS > NOTE_GAP_TICKS) ? NOTE_ON_TICKS : NOTE_GAP_TICKS;
    localparam int unsigned DIV_W     = $clog2(TICK_DIV);
    localparam int unsigned TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_KEY_ECHO = 2'd1;
    localparam logic [1:0] S_NOTE_ON  = 2'd2;
    localparam logic [1:0] S_NOTE_GAP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        len_q, len_d;
    logic [7:0][2:0]   notes_q, notes_d;
    logic              pend_q, pend_d;
    logic [3:0]        tone_q, tone_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              acc_q, acc_d;

    logic [2:0] len_in_c, start_idx_c, next_idx_c;
    logic       start_rev_c, dir_rev_c, last_c, div_wrap_c, phase_end_c;
    logic       unused_pat_c;

    // Bit 3 of each pattern nibble is not part of the note code.
    assign unused_pat_c = ^{pattern[31], pattern[27], pattern[23], pattern[19],
                            pattern[15], pattern[11], pattern[7], pattern[3]};

`ifdef REVERSE_PLAY_EN
    logic rev_q, rev_d, rpend_q, rpend_d;

    assign start_rev_c = pend_q ? rpend_q : play_rev;
    assign dir_rev_c   = rev_q;

    always_comb begin
        rev_d   = rev_q;
        rpend_d = rpend_q;
        if (state_q == S_IDLE && (play_req || pend_q)) rev_d = start_rev_c;
        if (state_q == S_KEY_ECHO && play_req)         rpend_d = play_rev;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rev_q   <= 1'b0;
            rpend_q <= 1'b0;
        end else begin
            rev_q   <= rev_d;
            rpend_q <= rpend_d;
        end
    end
`else
    assign start_rev_c = 1'b0;
    assign dir_rev_c   = 1'b0;
`endif

    assign len_in_c    = (play_len > 4'd7) ? 3'd7 : play_len[2:0];
    assign start_idx_c = start_rev_c ? len_in_c : 3'd0;
    assign next_idx_c  = dir_rev_c ? (idx_q - 3'd1) : (idx_q + 3'd1);
    assign last_c      = (idx_q == (dir_rev_c ? 3'd0 : len_q));
    assign div_wrap_c  = (div_q == DIV_W'(TICK_DIV - 1));
    assign phase_end_c = div_wrap_c &&
                         (tick_q == ((state_q == S_NOTE_ON) ? TICK_W'(NOTE_ON_TICKS - 1)
                                                            : TICK_W'(NOTE_GAP_TICKS - 1)));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        tick_d  = '0;
        idx_d   = idx_q;
        len_d   = len_q;
        notes_d = notes_q;
        pend_d  = pend_q;
        tone_d  = tone_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        acc_d   = 1'b0;

        if (state_q == S_NOTE_ON || state_q == S_NOTE_GAP) begin
            div_d  = div_wrap_c ? '0 : div_q + DIV_W'(1);
            tick_d = div_wrap_c ? tick_q + TICK_W'(1) : tick_q;
            if (phase_end_c) begin
                div_d  = '0;
                tick_d = '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (play_req || pend_q) begin
                    for (int i = 0; i < 8; i++) notes_d[i] = pattern[4*i +: 3];
                    len_d   = len_in_c;
                    idx_d   = start_idx_c;
                    tone_d  = {1'b0, pattern[{start_idx_c, 2'b00} +: 3]};
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = S_NOTE_ON;
                end else if (key_valid) begin
                    acc_d = 1'b1;
                    if (key_release) begin
                        tone_d = 4'd0;
                    end else begin
                        tone_d  = key_code;
                        state_d = S_KEY_ECHO;
                    end
                end
            end
            S_KEY_ECHO: begin
                if (play_req) pend_d = 1'b1;
                if (key_valid) begin
                    acc_d  = 1'b1;
                    tone_d = key_code;
                end
                if (key_release) begin
                    tone_d  = 4'd0;
                    state_d = S_IDLE;
                end
            end
            S_NOTE_ON: begin
                if (phase_end_c) begin
                    tone_d  = 4'd0;
                    state_d = S_NOTE_GAP;
                end
            end
            default: begin
                if (phase_end_c) begin
                    if (last_c) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = next_idx_c;
                        tone_d  = {1'b0, notes_q[next_idx_c]};
                        state_d = S_NOTE_ON;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tick_q  <= '0;
            idx_q   <= 3'd0;
            len_q   <= 3'd0;
            notes_q <= '0;
            pend_q  <= 1'b0;
            tone_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            notes_q <= notes_d;
            pend_q  <= pend_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
        end
    end

    assign tone_out   = tone_q;
    assign led_out    = tone_q;
    assign play_busy  = busy_q;
    assign play_done  = done_q;
    assign key_accept = acc_q;

endmodule

// File: tb/tb_melody_output_scheduler.sv
// Self-checking bench for melody_output_scheduler: directed scenarios plus randomized playbacks
// compared against a per-note timeline computed from the pattern.
module tb_melody_output_scheduler;

    localparam int TICK_DIV = 4;
    localparam int ON_T     = 2;
    localparam int GAP_T    = 2;
    localparam int ON_CYC   = TICK_DIV * ON_T;
    localparam int GAP_CYC  = TICK_DIV * GAP_T;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pattern;
    logic [3:0]  play_len;
    logic        play_req;
    logic        play_rev;
    logic        play_busy;
    logic        play_done;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_release;
    logic        key_accept;
    logic [3:0]  tone_out;
    logic [3:0]  led_out;

    int n_cmp = 0;
    int n_err = 0;

    melody_output_scheduler #(
        .TICK_DIV(TICK_DIV), .NOTE_ON_TICKS(ON_T), .NOTE_GAP_TICKS(GAP_T)
    ) dut (
        .clk(clk), .reset(reset), .pattern(pattern), .play_len(play_len), .play_req(play_req),
`ifdef REVERSE_PLAY_EN
        .play_rev(play_rev),
`endif
        .play_busy(play_busy), .play_done(play_done), .key_valid(key_valid), .key_code(key_code),
        .key_release(key_release), .key_accept(key_accept), .tone_out(tone_out), .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] tone, input logic busy,
                           input logic done, input logic acc);
        chk({tag, "/tone"}, 32'(tone_out), 32'(tone));
        chk({tag, "/led"},  32'(led_out),  32'(tone));
        chk({tag, "/busy"}, 32'(play_busy), 32'(busy));
        chk({tag, "/done"}, 32'(play_done), 32'(done));
        chk({tag, "/acc"},  32'(key_accept), 32'(acc));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        play_req    = 1'b0;
        key_valid   = 1'b0;
        key_release = 1'b0;
    endtask

    function automatic logic [3:0] note_of(input logic [31:0] p, input int i);
        return 4'((p >> (4 * i)) & 32'h7);
    endfunction

    // Issue a request in the current cycle; returns in the first tone cycle.
    task automatic start_play(input logic [31:0] pat, input logic [3:0] len, input logic kv);
        pattern   = pat;
        play_len  = len;
        play_req  = 1'b1;
        key_valid = kv;
        key_code  = 4'($urandom);
        step();
        quiet();
    endtask

    // Expected timeline: each note sounds ON_CYC cycles then GAP_CYC silent, done the cycle after.
    task automatic run_playback(input logic [31:0] pat, input int len_req, input bit noise);
        int last;
        last = (len_req > 7) ? 7 : len_req;
        for (int i = 0; i <= last; i++) begin
            for (int c = 0; c < ON_CYC + GAP_CYC; c++) begin
                chk_out($sformatf("play n%0d c%0d", i, c),
                        (c < ON_CYC) ? note_of(pat, i) : 4'd0, 1'b1, 1'b0, 1'b0);
                if (noise) begin
                    play_req    = ($urandom_range(0, 7) == 0);
                    key_valid   = ($urandom_range(0, 3) == 0);
                    key_code    = 4'($urandom);
                    key_release = ($urandom_range(0, 3) == 0);
                    pattern     = $urandom;
                    play_len    = 4'($urandom);
                end
                step();
            end
        end
        quiet();
        chk_out("done", 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("after done", 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pat;
        int          len;
        logic [3:0]  code;

        reset    = 1'b1;
        pattern  = '0;
        play_len = '0;
        play_rev = 1'b0;
        key_code = '0;
        quiet();
        step();
        chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_out("idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // Basic three-note playback.
        start_play(32'h0000_0531, 4'd2, 1'b0);
        run_playback(32'h0000_0531, 2, 1'b0);

        // Idle key echo, release five cycles after the press.
        key_valid = 1'b1;
        key_code  = 4'd6;
        step();
        key_valid = 1'b0;
        chk_out("echo first", 4'd6, 1'b0, 1'b0, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk_out($sformatf("echo hold %0d", k), 4'd6, 1'b0, 1'b0, 1'b0);
        end
        key_release = 1'b1;
        step();
        key_release = 1'b0;
        chk_out("echo released", 4'd0, 1'b0, 1'b0, 1'b0);

        // Key press alongside the request plus key/request/pattern noise during playback.
        start_play(32'h0000_0531, 4'd2, 1'b1);
        run_playback(32'h0000_0531, 2, 1'b1);

        // Request while echoing: pending start two cycles after release.
        pat = $urandom;
        key_valid = 1'b1;
        key_code  = 4'd9;
        step();
        key_valid = 1'b0;
        chk_out("pend echo", 4'd9, 1'b0, 1'b0, 1'b1);
        pattern  = pat;
        play_len = 4'd3;
        play_req = 1'b1;
        step();
        play_req  = 1'b0;
        chk_out("pend req", 4'd9, 1'b0, 1'b0, 1'b0);
        key_valid = 1'b1;
        key_code  = 4'd3;
        step();
        key_valid = 1'b0;
        chk_out("pend new key", 4'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("pend hold", 4'd3, 1'b0, 1'b0, 1'b0);
        key_release = 1'b1;
        step();
        key_release = 1'b0;
        chk_out("pend idle gap", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        run_playback(pat, 3, 1'b0);

        // Length clamp and rest note.
        start_play(32'h7654_3210, 4'hF, 1'b0);
        run_playback(32'h7654_3210, 15, 1'b0);

        // Simultaneous press and release in idle, then a stray release.
        key_valid   = 1'b1;
        key_release = 1'b1;
        key_code    = 4'd5;
        step();
        quiet();
        chk_out("press+release", 4'd0, 1'b0, 1'b0, 1'b1);
        key_release = 1'b1;
        step();
        key_release = 1'b0;
        chk_out("stray release", 4'd0, 1'b0, 1'b0, 1'b0);
        key_valid = 1'b1;
        key_code  = 4'd7;
        step();
        key_valid = 1'b0;
        chk_out("press after", 4'd7, 1'b0, 1'b0, 1'b1);
        key_release = 1'b1;
        step();
        key_release = 1'b0;
        chk_out("release after", 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a note.
        start_play(32'h0000_4446, 4'd2, 1'b0);
        step();
        step();
        chk_out("pre reset", 4'd6, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_out("async reset", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk_out($sformatf("post reset %0d", k), 4'd0, 1'b0, 1'b0, 1'b0);
        end
        pat = $urandom;
        start_play(pat, 4'd1, 1'b0);
        run_playback(pat, 1, 1'b0);

        // Randomized playbacks and echoes.
        for (int r = 0; r < 6; r++) begin
            pat = $urandom;
            len = int'($urandom_range(0, 15));
            start_play(pat, 4'(len), 1'($urandom));
            run_playback(pat, len, 1'($urandom));
            code = 4'($urandom);
            key_valid = 1'b1;
            key_code  = code;
            step();
            key_valid = 1'b0;
            chk_out($sformatf("rnd echo %0d", r), code, 1'b0, 1'b0, 1'b1);
            key_release = 1'b1;
            step();
            key_release = 1'b0;
            chk_out($sformatf("rnd release %0d", r), 4'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
